// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl: M1-stage data-memory request controller.
// Translates virtual addresses (kseg0/kseg1 unmapped, everything else via the
// DTLB lookup presented alongside the op), raises address/TLB exceptions,
// issues pipelined DCache requests with a shared credit pool of DEPTH, and
// returns responses strictly in order through a small response buffer.
// Flush marks in-flight requests as killed instead of forgetting them, so the
// data_ok stream from the cache stays aligned with the outstanding FIFO.
module dmem_req_ctrl #(
  parameter int DEPTH        = 2,
  parameter bit KSEG0_CACHED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  // op from the pipeline
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_vaddr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  // DTLB lookup for req_vaddr
  input  logic        tlb_found,
  input  logic [19:0] tlb_pfn,
  input  logic [2:0]  tlb_c,
  input  logic        tlb_d,
  input  logic        tlb_v,
  // exception report
  output logic        ex_valid,
  output logic [4:0]  ex_code,
  output logic        ex_refill,
  output logic [31:0] ex_badvaddr,
  // DCache request channel
  output logic        cache_req_valid,
  input  logic        cache_req_ready,
  output logic        cache_req_we,
  output logic [31:0] cache_req_paddr,
  output logic [3:0]  cache_req_wstrb,
  output logic [31:0] cache_req_wdata,
  output logic        cache_req_uncached,
  // DCache response channel
  input  logic        cache_resp_valid,
  input  logic [31:0] cache_resp_rdata,
  // in-order response to the pipeline
  output logic        resp_valid,
  output logic        resp_we,
  output logic [31:0] resp_rdata,
  input  logic        resp_ready,
  // status
  output logic        busy,
  output logic        protocol_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef struct packed {
    logic we;
    logic kill;
  } ost_t;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } rsp_t;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    ptr_nxt = (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------- translate
  logic mapped, misalign;
  logic fault, refill;
  logic [4:0] code;

  assign mapped   = (req_vaddr[31:30] != 2'b10);
  assign misalign = ((req_size == 2'd1) & req_vaddr[0]) |
                    (req_size[1] & (req_vaddr[1:0] != 2'b00));

  // Exception priority: alignment, then TLB miss, invalid, then write-protect.
  always_comb begin
    fault  = 1'b0;
    refill = 1'b0;
    code   = 5'd0;
    if (misalign) begin
      fault = 1'b1;
      code  = req_we ? EXC_ADES : EXC_ADEL;
    end else if (mapped & ~tlb_found) begin
      fault  = 1'b1;
      refill = 1'b1;
      code   = req_we ? EXC_TLBS : EXC_TLBL;
    end else if (mapped & ~tlb_v) begin
      fault = 1'b1;
      code  = req_we ? EXC_TLBS : EXC_TLBL;
    end else if (mapped & req_we & ~tlb_d) begin
      fault = 1'b1;
      code  = EXC_MOD;
    end
  end

  assign ex_valid    = req_valid & fault & ~flush;
  assign ex_code     = code;
  assign ex_refill   = refill;
  assign ex_badvaddr = req_vaddr;

  // ------------------------------------------------------------- credit/issue
  logic [CW-1:0] ost_cnt, rsp_cnt;
  logic [CW:0]   occ;
  logic          credit;

  assign occ    = {1'b0, ost_cnt} + {1'b0, rsp_cnt};
  assign credit = (occ < DEPTH_W);
  assign busy   = (occ != '0);

  assign cache_req_valid    = req_valid & ~flush & credit & ~fault;
  assign cache_req_we       = req_we;
  assign cache_req_wstrb    = req_wstrb;
  assign cache_req_wdata    = req_wdata;
  assign cache_req_paddr    = mapped ? {tlb_pfn, req_vaddr[11:0]}
                                     : {3'b000, req_vaddr[28:0]};
  assign cache_req_uncached = mapped ? (tlb_c != 3'd3)
                                     : (req_vaddr[29] | ~KSEG0_CACHED);

  // Faulting ops are consumed so the pipeline can take the exception.
  assign req_ready = (cache_req_valid & cache_req_ready) | ex_valid;

  // -------------------------------------------------------- outstanding FIFO
  ost_t [DEPTH-1:0] ost_q;
  logic [PW-1:0]    ost_wr, ost_rd;
  logic             ost_push, ost_pop;

  assign ost_push = cache_req_valid & cache_req_ready;
  assign ost_pop  = cache_resp_valid & (ost_cnt != '0);

  // Track issued requests; flush marks every in-flight entry as killed.
  always_ff @(posedge clk) begin
    if (reset) begin
      ost_q   <= '0;
      ost_wr  <= '0;
      ost_rd  <= '0;
      ost_cnt <= '0;
    end else begin
      if (ost_push) begin
        ost_q[ost_wr] <= '{we: req_we, kill: 1'b0};
        ost_wr        <= ptr_nxt(ost_wr);
      end
      if (ost_pop)
        ost_rd <= ptr_nxt(ost_rd);
      if (flush)
        for (int i = 0; i < DEPTH; i++)
          ost_q[i].kill <= 1'b1;
      ost_cnt <= ost_cnt + CW'(ost_push) - CW'(ost_pop);
    end
  end

  // ----------------------------------------------------------- response FIFO
  rsp_t [DEPTH-1:0] rsp_q;
  logic [PW-1:0]    rsp_wr, rsp_rd;
  logic             rsp_push, rsp_pop;

  // Data arriving during flush belongs to work being discarded.
  assign rsp_push = ost_pop & ~ost_q[ost_rd].kill & ~flush;
  assign rsp_pop  = resp_valid & resp_ready & ~flush;

  // Response storage; stores return zero data.
  always_ff @(posedge clk) begin
    if (rsp_push)
      rsp_q[rsp_wr] <= '{we: ost_q[ost_rd].we,
                         data: ost_q[ost_rd].we ? 32'd0 : cache_resp_rdata};
  end

  // Response pointers and count; flush empties the buffer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rsp_wr  <= '0;
      rsp_rd  <= '0;
      rsp_cnt <= '0;
    end else begin
      if (rsp_push)
        rsp_wr <= ptr_nxt(rsp_wr);
      if (rsp_pop)
        rsp_rd <= ptr_nxt(rsp_rd);
      rsp_cnt <= rsp_cnt + CW'(rsp_push) - CW'(rsp_pop);
    end
  end

  assign resp_valid = (rsp_cnt != '0);
  assign resp_we    = rsp_q[rsp_rd].we;
  assign resp_rdata = rsp_q[rsp_rd].data;

  // Sticky flag for a data_ok with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset)
      protocol_err <= 1'b0;
    else if (cache_resp_valid & (ost_cnt == '0))
      protocol_err <= 1'b1;
  end

endmodule
